block_data_memory: RTL and testbench

Word-organised main data memory sitting directly downstream of the data cache: services whole-block (32-bit, 4-byte) reads for cache fills and whole-block writes for dirty write-backs. Models a fixed multi-cycle access latency with a busywait handshake; the cache holds its request until busywait falls. Storage is 64 blocks × 32 bits (256 bytes, 6-bit block address).

---
 rtl/block_data_memory.sv | 154 +++++++++++++++
 tb/tb_block_data_memory.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/block_data_memory.sv
// Block-organised main data memory (64 x 32-bit) behind the data cache, with a
// fixed multi-cycle busywait handshake. Optional per-byte parity: DMEM_PARITY_EN.
module block_data_memory #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
`ifdef DMEM_PARITY_EN
    input  logic        parity_inject,
    output logic        parity_error,
`endif
    output logic [31:0] readdata,
    output logic        busywait
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state_reg;
    logic [3:0]  counter_reg;
    logic [5:0]  addr_reg;
    logic [31:0] wdata_reg;
    logic        op_write_reg;
    logic [31:0] readdata_reg;

    logic        accept;
    logic        complete;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_rd [DEPTH];

    assign accept    = (state_reg == IDLE) && (read || write);
    assign complete  = (state_reg == BUSY) && (counter_reg == 4'd0);
    assign mem_wr_en = complete && op_write_reg;
    assign mem_rd_en = complete && !op_write_reg;

    // IDLE raises busywait in the same cycle as the request so the cache never
    // sees a spurious low; reset forces it low regardless of a held request.
    always_comb begin
        busywait = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE:    busywait = read | write;
                BUSY:    busywait = 1'b1;
                default: busywait = 1'b0;
            endcase
        end
    end

    assign readdata = readdata_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            counter_reg  <= 4'd0;
            addr_reg     <= 6'd0;
            wdata_reg    <= 32'h0;
            op_write_reg <= 1'b0;
            readdata_reg <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg     <= address;
                        wdata_reg    <= writedata;
                        op_write_reg <= write;
                        counter_reg  <= 4'(LATENCY - 1);
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter_reg != 4'd0) begin
                        counter_reg <= counter_reg - 4'd1;
                    end else begin
                        if (!op_write_reg) begin
                            readdata_reg <= mem_rd[addr_reg];
                        end
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef DMEM_PARITY_EN
    logic       inject_reg;
    logic [3:0] wpar;
    logic [3:0] rpar_calc;
    logic [3:0] par_rd [DEPTH];

    // Parity bit b covers data lane [8b+7:8b]; byte 0 (offset 00) is lane 3.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_par_lane
            assign wpar[gi]      = ^wdata_reg[8*gi +: 8];
            assign rpar_calc[gi] = ^mem_rd[addr_reg][8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inject_reg   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (accept) begin
                inject_reg   <= parity_inject;
                parity_error <= 1'b0;
            end else if (mem_rd_en) begin
                parity_error <= |(rpar_calc ^ par_rd[addr_reg]);
            end
        end
    end
`endif

    // Each block is its own register so the whole array clears on reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_block
            logic [31:0] word_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    word_reg <= 32'h0;
                end else if (mem_wr_en && (addr_reg == 6'(gi))) begin
                    word_reg <= wdata_reg;
                end
            end

            assign mem_rd[gi] = word_reg;

`ifdef DMEM_PARITY_EN
            logic [3:0] par_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    par_reg <= 4'h0;
                end else if (mem_wr_en && (addr_reg == 6'(gi))) begin
                    par_reg <= wpar ^ {inject_reg, 3'b000};
                end
            end

            assign par_rd[gi] = par_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: latency, read/write, held requests,
// mid-access reset and (with DMEM_PARITY_EN) parity injection.
`timescale 1ns/1ps
module tb_block_data_memory;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
`ifdef DMEM_PARITY_EN
    logic        parity_inject;
    logic        parity_error;
`endif

    int n_vec = 0;
    int n_err = 0;

    block_data_memory #(.LATENCY(4), .DEPTH(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
`ifdef DMEM_PARITY_EN
        .parity_inject (parity_inject),
        .parity_error  (parity_error),
`endif
        .readdata  (readdata),
        .busywait  (busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Raise a request just after a rising edge, count busy cycles (sampled on
    // falling edges) until DONE, capture readdata there, then drop the request.
    task automatic access(input logic is_rd, input logic is_wr, input logic [5:0] a,
                          input logic [31:0] d, input logic inj,
                          output int busy_cycles, output logic [31:0] rd);
        read      = is_rd;
        write     = is_wr;
        address   = a;
        writedata = d;
`ifdef DMEM_PARITY_EN
        parity_inject = inj;
`else
        if (inj) begin end
`endif
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busywait) busy_cycles++;
            else break;
        end
        rd    = readdata;
        read  = 1'b0;
        write = 1'b0;
`ifdef DMEM_PARITY_EN
        parity_inject = 1'b0;
`endif
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        logic [31:0] rd;

        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = 6'h0;
        writedata = 32'h0;
`ifdef DMEM_PARITY_EN
        parity_inject = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_busywait", {31'h0, busywait}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        access(1'b1, 1'b0, 6'h05, 32'h0, 1'b0, bc, rd);
        check("rd05_busy_cycles", 32'(bc), 32'd5);
        check("rd05_data", rd, 32'h0);

        access(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 1'b0, bc, rd);
        check("wr2A_busy_cycles", 32'(bc), 32'd5);
        check("wr2A_readdata_unchanged", rd, 32'h0);

        access(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, bc, rd);
        check("rd2A_data", rd, 32'hDEADBEEF);

        access(1'b1, 1'b1, 6'h01, 32'h11223344, 1'b0, bc, rd);
        check("rdwr01_readdata_unchanged", rd, 32'hDEADBEEF);
        access(1'b1, 1'b0, 6'h01, 32'h0, 1'b0, bc, rd);
        check("rd01_data", rd, 32'h11223344);

        // Start a read of 2A, then change address and drop the request in BUSY.
        read    = 1'b1;
        address = 6'h2A;
        @(posedge clock);
        #1;
        address = 6'h3F;
        read    = 1'b0;
        bc = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (busywait) bc++;
            else break;
        end
        check("midbusy_busy_cycles", 32'(bc), 32'd5);
        check("midbusy_data", readdata, 32'hDEADBEEF);
        @(posedge clock);
        #1;

        // Write-back followed by fill with the request held across DONE.
        read      = 1'b0;
        write     = 1'b1;
        address   = 6'h3F;
        writedata = 32'h0BADF00D;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!busywait) break;
        end
        write = 1'b0;
        read  = 1'b1;
        @(posedge clock);
        #1;
        access(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0, bc, rd);
        check("b2b_fill_busy_cycles", 32'(bc), 32'd5);
        check("b2b_fill_data", rd, 32'h0BADF00D);

        // Reset in the middle of a write: access discarded, array cleared.
        write     = 1'b1;
        address   = 6'h10;
        writedata = 32'hCAFEF00D;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("pre_reset_busywait", {31'h0, busywait}, 32'h1);
        reset = 1'b1;
        write = 1'b0;
        #1;
        check("reset_busywait_immediate", {31'h0, busywait}, 32'h0);
        check("reset_readdata_cleared", readdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        access(1'b1, 1'b0, 6'h10, 32'h0, 1'b0, bc, rd);
        check("rd10_after_reset", rd, 32'h0);
        check("rd10_busy_cycles", 32'(bc), 32'd5);
        access(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, bc, rd);
        check("rd2A_after_reset", rd, 32'h0);

`ifdef DMEM_PARITY_EN
        access(1'b0, 1'b1, 6'h07, 32'hA5A5A5A5, 1'b1, bc, rd);
        access(1'b1, 1'b0, 6'h07, 32'h0, 1'b0, bc, rd);
        check("par_inject_data", rd, 32'hA5A5A5A5);
        check("par_inject_error", {31'h0, parity_error}, 32'h1);
        access(1'b0, 1'b1, 6'h07, 32'hA5A5A5A5, 1'b0, bc, rd);
        check("par_cleared_on_accept", {31'h0, parity_error}, 32'h0);
        access(1'b1, 1'b0, 6'h07, 32'h0, 1'b0, bc, rd);
        check("par_clean_error", {31'h0, parity_error}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
